// File: rtl/alu_pkg.sv
// Shared types for the alu_seq datapath: the opcode encoding, the flag bundle
// and the first reserved opcode.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_ADC   = 4'd8,
    OP_SBB   = 4'd9,
    OP_ASR   = 4'd10,
    OP_ROL   = 4'd11,
    OP_CMP   = 4'd12,
    OP_PASS  = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  localparam logic [3:0] OP_RSVD_MIN = 4'd14;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and flags for one operand pair.
// Subtract-type carry is the borrow.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  logic             c_st,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic               add_cin;
  logic               sub_cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [SHW-1:0]     rot;
  logic [2*WIDTH-1:0] rol_w;
  logic               rsvd;
  logic               carry_v;
  logic               ovf_v;
  logic [WIDTH-1:0]   flag_src;

  assign add_cin = (op == OP_ADC) && c_st;
  assign sub_cin = (op == OP_SBB) && c_st;
  assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
  assign diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_cin};
  assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
  assign rot     = SHW'(b % WIDTH);
  assign rol_w   = {a, a} << rot;
  assign rsvd    = (op >= OP_RSVD_MIN);

  always_comb begin
    result  = '0;
    carry_v = 1'b0;
    ovf_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        result  = sum[MSB:0];
        carry_v = sum[WIDTH];
        ovf_v   = add_ovf;
      end
      OP_SUB, OP_SBB: begin
        result  = diff[MSB:0];
        carry_v = diff[WIDTH];
        ovf_v   = sub_ovf;
      end
      OP_CMP: begin
        result  = a;
        carry_v = diff[WIDTH];
        ovf_v   = sub_ovf;
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = a << b;
      OP_SHR:  result = a >> b;
      OP_ASR:  result = $signed(a) >>> b;
      OP_ROL:  result = rol_w[2*WIDTH-1:WIDTH];
      OP_PASS: result = b;
      default: result = '0;
    endcase

    // CMP reports zero/neg of the difference while returning A
    flag_src    = (op == OP_CMP) ? diff[MSB:0] : result;
    flags.carry = carry_v;
    flags.ovf   = ovf_v;
    flags.zero  = !rsvd && (flag_src == '0);
    flags.neg   = !rsvd && flag_src[MSB];
  end

endmodule

// File: rtl/alu_seq.sv
// Registered, valid/ready-handshaked ALU with stored carry and sticky overflow.
// Define ALU_ACC_EN to add the accumulator and the use_acc operand select.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_ACC_EN
  input  logic             use_acc,
`endif
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             sticky_ovf
);

  logic             accept;
  logic             c_st;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] core_res;
  flags_t           core_flags;
  flags_t           flags_q;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef ALU_ACC_EN
  logic [WIDTH-1:0] acc;

  assign opa = use_acc ? acc : a;

  // CMP returns A as its result, so loading the result covers acc <- A too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (accept)
      acc <= core_res;
  end
`else
  assign opa = a;
`endif

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (opa),
    .b      (b),
    .op     (op_e'(op)),
    .c_st   (c_st),
    .result (core_res),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      flags_q    <= '0;
      c_st       <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        result    <= core_res;
        flags_q   <= core_flags;
        c_st      <= core_flags.carry;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && core_flags.ovf)
        sticky_ovf <= 1'b1;
      else if (clr_sticky)
        sticky_ovf <= 1'b0;
    end
  end

  assign carry = flags_q.carry;
  assign zero  = flags_q.zero;
  assign neg   = flags_q.neg;
  assign ovf   = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed test-plan beats, then random traffic.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         in_valid   = 1'b0;
  logic         out_ready  = 1'b0;
  logic         clr_sticky = 1'b0;
  logic [3:0]   op         = '0;
  logic [W-1:0] a          = '0;
  logic [W-1:0] b          = '0;
  logic         in_ready, out_valid, carry, zero, neg, ovf, sticky_ovf;
  logic [W-1:0] result;
`ifdef ALU_ACC_EN
  logic         use_acc    = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
`ifdef ALU_ACC_EN
    .use_acc    (use_acc),
`endif
    .clr_sticky (clr_sticky),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry      (carry),
    .zero       (zero),
    .neg        (neg),
    .ovf        (ovf),
    .sticky_ovf (sticky_ovf)
  );

  typedef struct {
    int res;
    bit c;
    bit z;
    bit n;
    bit o;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_ov = 0, m_cst = 0, m_sticky = 0;
  int   m_acc = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sgn(int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference: plain integer arithmetic on 8-bit values
  function automatic exp_t alu_model(int o, int x, int y, bit cin);
    exp_t e;
    int   full, sfull, fv, k;
    e = '{0, 0, 0, 0, 0};
    if (o >= 14) return e;
    fv = -1;
    case (o)
      0, 8: begin
        full  = x + y + ((o == 8) ? int'(cin) : 0);
        sfull = sgn(x) + sgn(y) + ((o == 8) ? int'(cin) : 0);
        e.res = full % 256;
        e.c   = full > 255;
        e.o   = (sfull > 127) || (sfull < -128);
      end
      1, 9, 12: begin
        full  = x - y - ((o == 9) ? int'(cin) : 0);
        sfull = sgn(x) - sgn(y) - ((o == 9) ? int'(cin) : 0);
        e.res = (full + 256) % 256;
        e.c   = full < 0;
        e.o   = (sfull > 127) || (sfull < -128);
        if (o == 12) begin
          fv    = e.res;
          e.res = x;
        end
      end
      2:  e.res = x & y;
      3:  e.res = x | y;
      4:  e.res = x ^ y;
      5:  e.res = (~x) & 255;
      6:  e.res = (y >= 8) ? 0 : ((x << y) & 255);
      7:  e.res = (y >= 8) ? 0 : (x >> y);
      10: e.res = (y >= 8) ? ((x >= 128) ? 255 : 0) : ((sgn(x) >>> y) & 255);
      11: begin
        k     = y % 8;
        e.res = ((x << k) | (x >> (8 - k))) & 255;
      end
      default: e.res = y;
    endcase
    if (fv < 0) fv = e.res;
    e.z = (fv == 0);
    e.n = (fv >= 128);
    return e;
  endfunction

  // Called off the clock edge; applies inputs for one cycle and updates the model
  task automatic drive(bit v, int o, int x, int y, bit ua, bit clr, bit ordy);
    exp_t e;
    int   opa;
    bit   rdy;
    in_valid   = v;
    op         = o[3:0];
    a          = x[W-1:0];
    b          = (o == 5) ? 'x : y[W-1:0];
    clr_sticky = clr;
    out_ready  = ordy;
`ifdef ALU_ACC_EN
    use_acc    = ua;
`endif
    rdy = !m_ov || ordy;
    #1 check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    if (v && rdy) begin
      opa = x;
`ifdef ALU_ACC_EN
      if (ua) opa = m_acc;
`endif
      e = alu_model(o, opa, y, m_cst);
      sb_q.push_back(e);
      m_cst = e.c;
      m_acc = e.res;
      if (e.o) m_sticky = 1;
      else if (clr) m_sticky = 0;
      m_ov = 1;
    end else begin
      if (ordy) m_ov = 0;
      if (clr) m_sticky = 0;
    end
    @(posedge clk);
    #2;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    check("sticky_ovf", {31'b0, sticky_ovf}, {31'b0, m_sticky});
  endtask

  task automatic check_out(string tag, int r, bit c, bit z, bit n, bit o);
    check({tag, ".result"}, {24'b0, result}, r);
    check({tag, ".carry"}, {31'b0, carry}, {31'b0, c});
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, z});
    check({tag, ".neg"}, {31'b0, neg}, {31'b0, n});
    check({tag, ".ovf"}, {31'b0, ovf}, {31'b0, o});
  endtask

  // Monitor: compares every result the consumer takes against the scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: actual result %0h, expected no output", result);
        end else begin
          e = sb_q.pop_front();
          check("mon.result", {24'b0, result}, e.res);
          check("mon.carry", {31'b0, carry}, {31'b0, e.c});
          check("mon.zero", {31'b0, zero}, {31'b0, e.z});
          check("mon.neg", {31'b0, neg}, {31'b0, e.n});
          check("mon.ovf", {31'b0, ovf}, {31'b0, e.o});
        end
      end
    end
  end

  initial begin : stim
    bit v, ordy, clr;
    int o, y;
    #3;
    check_out("reset", 0, 0, 0, 0, 0);
    check("reset.out_valid", {31'b0, out_valid}, 0);
    check("reset.in_ready", {31'b0, in_ready}, 1);
    check("reset.sticky", {31'b0, sticky_ovf}, 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #2;

    drive(1, 0, 'hF0, 'h20, 0, 0, 1);  check_out("add_f0_20", 'h10, 1, 0, 0, 0);
    drive(1, 1, 'h03, 'h05, 0, 0, 1);  check_out("sub_03_05", 'hFE, 1, 0, 1, 0);
    drive(1, 0, 'hFF, 'h01, 0, 0, 1);  check_out("add_ff_01", 'h00, 1, 1, 0, 0);
    drive(1, 8, 'h00, 'h00, 0, 0, 1);  check_out("adc_00_00", 'h01, 0, 0, 0, 0);
    drive(1, 9, 'h05, 'h05, 0, 0, 1);  check_out("sbb_05_05", 'h00, 0, 1, 0, 0);

    drive(1, 0, 'h7F, 'h01, 0, 0, 1);  check_out("add_7f_01", 'h80, 0, 0, 1, 1);
    check("sticky_set", {31'b0, sticky_ovf}, 1);
    drive(1, 2, 'h80, 'hFF, 0, 0, 1);  check_out("and_after_ovf", 'h80, 0, 0, 1, 0);
    check("sticky_hold", {31'b0, sticky_ovf}, 1);
    drive(0, 0, 0, 0, 0, 1, 1);
    check("sticky_clr", {31'b0, sticky_ovf}, 0);
    drive(1, 0, 'h7F, 'h01, 0, 1, 1);
    check("sticky_set_wins", {31'b0, sticky_ovf}, 1);
    drive(0, 0, 0, 0, 0, 1, 1);

    drive(1, 6,  'h96, 9,  0, 0, 1);  check_out("shl_9", 'h00, 0, 1, 0, 0);
    drive(1, 10, 'h96, 2,  0, 0, 1);  check_out("asr_2", 'hE5, 0, 0, 1, 0);
    drive(1, 10, 'h96, 12, 0, 0, 1);  check_out("asr_12", 'hFF, 0, 0, 1, 0);
    drive(1, 11, 'h96, 9,  0, 0, 1);  check_out("rol_9", 'h2D, 0, 0, 0, 0);
    drive(1, 7,  'h96, 0,  0, 0, 1);  check_out("shr_0", 'h96, 0, 0, 1, 0);
    drive(1, 5,  'h96, 0,  0, 0, 1);  check_out("not_xb", 'h69, 0, 0, 0, 0);
    drive(1, 14, 'h12, 'h34, 0, 0, 1); check_out("rsvd_14", 'h00, 0, 0, 0, 0);
    drive(1, 12, 'h05, 'h07, 0, 0, 1); check_out("cmp_05_07", 'h05, 1, 0, 1, 0);

    // Backpressure: hold the 0x03 result for five cycles while offering beats
    drive(1, 0, 'h01, 'h02, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 4, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 0, 0);
      check("stall.result", {24'b0, result}, 'h03);
    end
    drive(1, 3, 'h50, 'h05, 0, 0, 1);
    check_out("release", 'h55, 0, 0, 0, 0);

    // Reset in the middle of a stall discards the held result
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 0);
    check("async_rst.out_valid", {31'b0, out_valid}, 0);
    check("async_rst.in_ready", {31'b0, in_ready}, 1);
    check("async_rst.sticky", {31'b0, sticky_ovf}, 0);
    sb_q.delete();
    m_ov = 0; m_cst = 0; m_acc = 0; m_sticky = 0;
    #2 rst_n = 1'b1;

`ifdef ALU_ACC_EN
    drive(1, 0, 3, 4, 0, 0, 1);      check_out("acc_add_3_4", 'h07, 0, 0, 0, 0);
    drive(1, 0, 'hAA, 5, 1, 0, 1);   check_out("acc_add_5", 'h0C, 0, 0, 0, 0);
`endif

    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      clr  = (v && ordy) ? ($urandom_range(0, 7) == 0) : 1'b0;
      o    = int'($urandom_range(0, 15));
      y    = $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
      drive(v, o, int'($urandom_range(0, 255)), y, 1'($urandom_range(0, 1)), clr, ordy);
    end

    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
